priority_encoder_queue: RTL

- Sequential 8-to-3 encoder. It is the inverse partner of the 3-bit one-hot decoder: one-hot request lines in, binary index out.
- Request pulses are latched into a sticky pending register. Pending bits are then issued one at a time, highest priority first, as a binary index with a matching one-hot echo.
- Output uses a valid/ready handshake. Used as the interrupt/request-select front end that feeds index-addressed logic in the CPU designs.

---
 rtl/priority_encoder_queue.sv | 93 +++++++++
 1 files changed

// File: rtl/priority_encoder_queue.sv
// Sequential 8-to-3 priority encoder: sticky pending requests are issued one at a
// time, lowest index first, through a valid/ready output slot.
module priority_encoder_queue #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_in,
    input  logic             clear_all,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    output logic [WIDTH-1:0] out_onehot,
    output logic [WIDTH-1:0] pending,
    output logic             overflow
);

    typedef enum logic {
        IDLE,
        VALID
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               overflow_q, overflow_d;

    logic [IDX_W-1:0]   win_idx;
    logic [WIDTH-1:0]   win_mask;
    logic [WIDTH-1:0]   load_mask;
    logic               found;
    logic               load;

    // Lowest set bit of the registered pending set wins.
    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found && pending_q[i]) begin
                win_idx = IDX_W'(i);
                found   = 1'b1;
            end
        end
        win_mask = pending_q & (~pending_q + WIDTH'(1));
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        load       = (pending_q != '0) && ((state_q == IDLE) || out_ready);
        load_mask  = load ? win_mask : '0;
        pending_d  = (pending_q & ~load_mask) | req_in;
        overflow_d = |(req_in & pending_q & ~load_mask);

        if (load) begin
            state_d = VALID;
            idx_d   = win_idx;
        end else if ((state_q == VALID) && out_ready) begin
            state_d = IDLE;
            idx_d   = '0;
        end

        // Flush overrides loads, accepts and incoming requests on the same edge.
        if (clear_all) begin
            state_d    = IDLE;
            idx_d      = '0;
            pending_d  = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_valid  = (state_q == VALID);
    assign out_index  = idx_q;
    assign out_onehot = (state_q == VALID) ? (WIDTH'(1) << idx_q) : '0;
    assign pending    = pending_q;
    assign overflow   = overflow_q;

endmodule
